// File: rtl/me_pkg.sv
// -----------------------------------------------------------------------------
// me_pkg
// Shared types and width helpers for the motion-estimation search engine.
//   me_state_t : engine control states (IDLE, RUN, DRAIN, DONE)
//   sad_width  : bits needed for a full-block SAD without overflow
//   idx_width  : bits needed to index n items (at least 1)
// -----------------------------------------------------------------------------
package me_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } me_state_t;

    // Worst case is every pixel differing by the full pixel range.
    function automatic int sad_width(input int pix_w, input int blk);
        return $clog2(blk * blk * ((1 << pix_w) - 1) + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/me_sad_lane.sv
// -----------------------------------------------------------------------------
// me_sad_lane
// One vertical candidate: sums |crt - pre| across a BLK-pixel row and
// accumulates the row sums into a block SAD.
//   clk, rst  : clock, synchronous active-high reset
//   en        : accepted beat; updates the accumulator
//   first     : beat is row 0, so the accumulator restarts from this row
//   crt_row   : current-block row, pixel 0 in LSBs
//   pre_row   : reference row for this lane, pixel 0 in LSBs
//   acc       : registered running SAD
// -----------------------------------------------------------------------------
module me_sad_lane
    import me_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int BLK   = 8,
    parameter int SAD_W = sad_width(PIX_W, BLK)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   first,
    input  logic [BLK*PIX_W-1:0]   crt_row,
    input  logic [BLK*PIX_W-1:0]   pre_row,
    output logic [SAD_W-1:0]       acc
);

    logic [PIX_W-1:0] diff [BLK];
    logic [SAD_W-1:0] row_sum;

    always_comb begin
        row_sum = '0;
        for (int p = 0; p < BLK; p++) begin
            if (crt_row[p*PIX_W +: PIX_W] > pre_row[p*PIX_W +: PIX_W])
                diff[p] = crt_row[p*PIX_W +: PIX_W] - pre_row[p*PIX_W +: PIX_W];
            else
                diff[p] = pre_row[p*PIX_W +: PIX_W] - crt_row[p*PIX_W +: PIX_W];
            row_sum = row_sum + SAD_W'(diff[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= first ? row_sum : acc + row_sum;
    end

endmodule

// File: rtl/me_search_engine.sv
// -----------------------------------------------------------------------------
// me_search_engine
// Full-search block matcher: LANES vertical candidates in parallel, COLS
// horizontal candidates in sequence, reporting the minimum SAD and its vector.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begins a search when idle (ignored otherwise)
//   early_en, thresh  : early-termination enable/threshold, latched at start
//   in_valid/in_ready : row-beat handshake
//   crt_row, pre_rows : current row and one reference row per lane
//   busy, done        : busy in RUN/DRAIN; done pulses for one cycle
//   early_term        : search stopped on threshold
//   sad_min, mv_x/y   : result, held until the next start
//   state_dbg         : current control state
//
// Handshake: a beat transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on state (high in RUN), never
// on in_valid; the source may drop in_valid at any time and the row/column
// counters simply hold. Beats arrive row 0..BLK-1 within a column, columns
// 0..COLS-1.
// -----------------------------------------------------------------------------
module me_search_engine
    import me_pkg::*;
#(
    parameter  int PIX_W = 8,
    parameter  int BLK   = 8,
    parameter  int LANES = 16,
    parameter  int COLS  = 16,
    parameter  int SAD_W = sad_width(PIX_W, BLK),
    localparam int XW    = idx_width(COLS),
    localparam int YW    = idx_width(LANES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       early_en,
    input  logic [SAD_W-1:0]           thresh,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BLK*PIX_W-1:0]       crt_row,
    input  logic [LANES*BLK*PIX_W-1:0] pre_rows,
    output logic                       busy,
    output logic                       done,
    output logic                       early_term,
    output logic [SAD_W-1:0]           sad_min,
    output logic [XW-1:0]              mv_x,
    output logic [YW-1:0]              mv_y,
    output logic [1:0]                 state_dbg
);

    localparam int RW  = idx_width(BLK);
    localparam int LOG = idx_width(LANES);
    localparam int P   = 1 << LOG;

    me_state_t        state, state_nx;
    logic             drain_cnt;
    logic [RW-1:0]    row;
    logic [XW-1:0]    col;
    logic             beat, first_row, last_row, last_col;
    logic             early_en_r;
    logic [SAD_W-1:0] thresh_r;
    logic             sad_vld;
    logic [XW-1:0]    sad_col;
    logic [SAD_W-1:0] lane_acc [LANES];
    logic [SAD_W-1:0] best_sad;
    logic [YW-1:0]    best_lane;
    logic             upd, early_hit;

    assign beat      = in_valid & in_ready;
    assign first_row = (row == '0);
    assign last_row  = (row == RW'(BLK - 1));
    assign last_col  = (col == XW'(COLS - 1));
    assign state_dbg = state;

    // Strictly-smaller update keeps the earliest column on ties; once a
    // threshold hit is taken, late columns still in flight are discarded.
    assign upd       = sad_vld && !early_term && (best_sad < sad_min);
    assign early_hit = upd && early_en_r && (best_sad <= thresh_r);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        me_sad_lane #(
            .PIX_W (PIX_W),
            .BLK   (BLK),
            .SAD_W (SAD_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (beat),
            .first   (first_row),
            .crt_row (crt_row),
            .pre_row (pre_rows[l*BLK*PIX_W +: BLK*PIX_W]),
            .acc     (lane_acc[l])
        );
    end

    // Min tree over lanes, level 0 = leaves. Padding leaves are all-ones and
    // sit right of every real lane; the right child wins only when strictly
    // smaller, so ties resolve to the lowest lane.
    for (genvar d = 0; d <= LOG; d++) begin : g_lvl
        localparam int N = P >> d;
        logic [SAD_W-1:0] sad [N];
        logic [YW-1:0]    idx [N];
        for (genvar k = 0; k < N; k++) begin : g_node
            if (d == 0) begin : g_leaf
                if (k < LANES) begin : g_real
                    assign sad[k] = lane_acc[k];
                end else begin : g_pad
                    assign sad[k] = '1;
                end
                assign idx[k] = YW'(k);
            end else begin : g_cmp
                logic take_right;
                assign take_right = g_lvl[d-1].sad[2*k+1] < g_lvl[d-1].sad[2*k];
                assign sad[k] = take_right ? g_lvl[d-1].sad[2*k+1] : g_lvl[d-1].sad[2*k];
                assign idx[k] = take_right ? g_lvl[d-1].idx[2*k+1] : g_lvl[d-1].idx[2*k];
            end
        end
    end

    assign best_sad  = g_lvl[LOG].sad[0];
    assign best_lane = g_lvl[LOG].idx[0];

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if ((in_valid && last_row && last_col) || early_hit)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Two cycles: lane accumulate, then compare/update.
                if (drain_cnt)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt  <= 1'b0;
            row        <= '0;
            col        <= '0;
            sad_vld    <= 1'b0;
            sad_col    <= '0;
            sad_min    <= '1;
            mv_x       <= '0;
            mv_y       <= '0;
            early_term <= 1'b0;
            early_en_r <= 1'b0;
            thresh_r   <= '0;
        end else begin
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            sad_vld   <= beat & last_row;
            sad_col   <= col;
            if (state == IDLE && start) begin
                row        <= '0;
                col        <= '0;
                sad_min    <= '1;
                mv_x       <= '0;
                mv_y       <= '0;
                early_term <= 1'b0;
                early_en_r <= early_en;
                thresh_r   <= thresh;
            end
            if (beat) begin
                if (last_row) begin
                    row <= '0;
                    col <= last_col ? '0 : col + XW'(1);
                end else begin
                    row <= row + RW'(1);
                end
            end
            if (upd) begin
                sad_min <= best_sad;
                mv_x    <= sad_col;
                mv_y    <= best_lane;
            end
            if (early_hit)
                early_term <= 1'b1;
        end
    end

endmodule

// File: tb/tb_me_search_engine.sv
// -----------------------------------------------------------------------------
// tb_me_search_engine
// Drives row beats for whole searches, predicts each search result with a
// loop-based block-matching model, and checks results when done pulses.
// -----------------------------------------------------------------------------
module tb_me_search_engine;

    localparam int PIX_W = 8;
    localparam int BLK   = 8;
    localparam int LANES = 16;
    localparam int COLS  = 16;
    localparam int SAD_W = $clog2(BLK*BLK*(2**PIX_W-1)+1);
    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(LANES);
    localparam int EW    = 1 + SAD_W + XW + YW;
    localparam int BEATS = COLS * BLK;

    logic                       clk;
    logic                       rst;
    logic                       start;
    logic                       early_en;
    logic [SAD_W-1:0]           thresh;
    logic                       in_valid;
    logic                       in_ready;
    logic [BLK*PIX_W-1:0]       crt_row;
    logic [LANES*BLK*PIX_W-1:0] pre_rows;
    logic                       busy;
    logic                       done;
    logic                       early_term;
    logic [SAD_W-1:0]           sad_min;
    logic [XW-1:0]              mv_x;
    logic [YW-1:0]              mv_y;
    logic [1:0]                 state_dbg;

    me_search_engine #(
        .PIX_W (PIX_W),
        .BLK   (BLK),
        .LANES (LANES),
        .COLS  (COLS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .early_en   (early_en),
        .thresh     (thresh),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .crt_row    (crt_row),
        .pre_rows   (pre_rows),
        .busy       (busy),
        .done       (done),
        .early_term (early_term),
        .sad_min    (sad_min),
        .mv_x       (mv_x),
        .mv_y       (mv_y),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required done earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- state ----------------
    int errors = 0;
    int checks = 0;
    int last_beat_cycle = 0;
    int beats_acc = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp;

    int crt_pix [BLK][BLK];
    int pre_pix [COLS][LANES][BLK][BLK];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- data set-up ----------------
    // mode 0: random crt, every pre pixel differs by exactly 1
    // mode 1: crt all 255, pre all 0
    // mode 2: random crt, every pre pixel differs by 128
    // mode 3: random crt, pre within +/-3 (clamped)
    task automatic fill_base(input int mode);
        int v;
        for (int r = 0; r < BLK; r++)
            for (int p = 0; p < BLK; p++)
                crt_pix[r][p] = (mode == 1) ? 255 : int'($urandom_range(255));
        for (int c = 0; c < COLS; c++)
            for (int l = 0; l < LANES; l++)
                for (int r = 0; r < BLK; r++)
                    for (int p = 0; p < BLK; p++) begin
                        case (mode)
                            0: v = crt_pix[r][p] ^ 1;
                            1: v = 0;
                            2: v = crt_pix[r][p] ^ 128;
                            default: begin
                                v = crt_pix[r][p] + int'($urandom_range(6)) - 3;
                                if (v < 0) v = 0;
                                if (v > 255) v = 255;
                            end
                        endcase
                        pre_pix[c][l][r][p] = v;
                    end
    endtask

    // Candidate (c,l) gets SAD == target (target <= BLK*BLK).
    task automatic set_cand_sad(input int c, input int l, input int target);
        for (int r = 0; r < BLK; r++)
            for (int p = 0; p < BLK; p++)
                pre_pix[c][l][r][p] = (r*BLK + p < target) ? (crt_pix[r][p] ^ 1) : crt_pix[r][p];
    endtask

    // ---------------- reference model ----------------
    task automatic model(input bit en, input int thr, output logic [EW-1:0] e, output int stop_col);
        int best, bx, by, cmin, cl, s, d;
        bit hit;
        best = (1 << SAD_W) - 1; bx = 0; by = 0; hit = 0; stop_col = COLS - 1;
        for (int c = 0; c < COLS; c++) begin
            cmin = -1; cl = 0;
            for (int l = 0; l < LANES; l++) begin
                s = 0;
                for (int r = 0; r < BLK; r++)
                    for (int p = 0; p < BLK; p++) begin
                        d = crt_pix[r][p] - pre_pix[c][l][r][p];
                        s += (d < 0) ? -d : d;
                    end
                if (cmin < 0 || s < cmin) begin cmin = s; cl = l; end
            end
            if (cmin < best) begin
                best = cmin; bx = c; by = cl;
                if (en && best <= thr) begin hit = 1; stop_col = c; break; end
            end
        end
        e = {hit, SAD_W'(best), XW'(bx), YW'(by)};
    endtask

    // ---------------- driver ----------------
    task automatic drive_beat(input int k);
        int c, r;
        c = k / BLK; r = k % BLK;
        for (int p = 0; p < BLK; p++)
            crt_row[p*PIX_W +: PIX_W] = PIX_W'(crt_pix[r][p]);
        for (int l = 0; l < LANES; l++)
            for (int p = 0; p < BLK; p++)
                pre_rows[(l*BLK+p)*PIX_W +: PIX_W] = PIX_W'(pre_pix[c][l][r][p]);
    endtask

    task automatic wait_results();
        int t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("done_seen_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // abort_at >= 0: assert reset after that many accepted beats.
    task automatic run_search(input int gap_pct, input bit en, input int thr,
                              input bit spam_start, input int abort_at);
        logic [EW-1:0] e;
        int stop_col, k, guard, lo;
        bit ready_ok;
        e = '0; stop_col = COLS - 1;
        if (abort_at < 0) begin
            model(en, thr, e, stop_col);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        early_en = en; thresh = SAD_W'(thr); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; early_en = 1'b0; thresh = '0;
        k = 0; guard = 0; beats_acc = 0; ready_ok = 1;
        while (k < BEATS && guard < 5000) begin
            drive_beat(k);
            in_valid = ($urandom_range(99) >= gap_pct);
            start = spam_start && ($urandom_range(9) == 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                k++; beats_acc++; last_beat_cycle = cycle;
            end else if (!in_ready) begin
                ready_ok = 0;
                break;
            end
            @(posedge clk); #1;
            guard++;
            if (abort_at >= 0 && k == abort_at) begin
                in_valid = 1'b0; start = 1'b0; rst = 1'b1;
                @(posedge clk); @(posedge clk); #1;
                check("rst_in_ready", int'(in_ready), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_early_term", int'(early_term), 0);
                check("rst_sad_min", int'(sad_min), (1 << SAD_W) - 1);
                check("rst_mv_x", int'(mv_x), 0);
                check("rst_mv_y", int'(mv_y), 0);
                rst = 1'b0;
                return;
            end
        end
        check("beat_budget", int'(guard < 5000), 1);
        if (k == BEATS) begin
            // start during DRAIN must be ignored
            start = spam_start;
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("ready_held_in_run", int'(ready_ok), e[EW-1] ? 0 : 1);
        if (e[EW-1]) begin
            lo = (stop_col + 1) * BLK;
            check("early_beats_bounded", int'(beats_acc >= lo && beats_acc <= lo + 1), 1);
        end else begin
            check("beats_accepted", beats_acc, BEATS);
        end
        wait_results();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                check("early_term", int'(early_term), int'(e[EW-1]));
                check("sad_min", int'(sad_min), int'(e[EW-2 -: SAD_W]));
                check("mv_x", int'(mv_x), int'(e[XW+YW-1 -: XW]));
                check("mv_y", int'(mv_y), int'(e[YW-1:0]));
                if (!e[EW-1])
                    check("done_latency", cycle - last_beat_cycle, 3);
            end
        end
    end

    // ---------------- sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; early_en = 1'b0; thresh = '0;
        in_valid = 1'b0; crt_row = '0; pre_rows = '0; last_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_in_ready", int'(in_ready), 0);
        check("init_busy", int'(busy), 0);
        check("init_done", int'(done), 0);
        check("init_early_term", int'(early_term), 0);
        check("init_sad_min", int'(sad_min), (1 << SAD_W) - 1);
        check("init_mv_x", int'(mv_x), 0);
        check("init_mv_y", int'(mv_y), 0);
        rst = 1'b0;

        // exact match at lane 5, column 9
        fill_base(0);
        set_cand_sad(9, 5, 0);
        run_search(0, 0, 0, 0, -1);
        repeat (5) @(posedge clk);
        #1;
        check("hold_sad_min", int'(sad_min), int'(last_exp[EW-2 -: SAD_W]));
        check("hold_mv_x", int'(mv_x), int'(last_exp[XW+YW-1 -: XW]));
        check("hold_mv_y", int'(mv_y), int'(last_exp[YW-1:0]));
        check("hold_busy", int'(busy), 0);

        // worst case everywhere: ties keep first candidate
        fill_base(1);
        run_search(0, 0, 0, 0, -1);

        // tie between lanes and between columns
        fill_base(2);
        set_cand_sad(4, 3, 10);
        set_cand_sad(4, 7, 10);
        set_cand_sad(12, 1, 10);
        run_search(0, 0, 0, 0, -1);

        // early termination on column 2
        fill_base(2);
        set_cand_sad(2, 0, 15);
        run_search(0, 1, 20, 0, -1);

        // scenario 1 with ~50% input gaps
        fill_base(0);
        set_cand_sad(9, 5, 0);
        run_search(50, 0, 0, 0, -1);

        // reset mid-run, then clean run with spurious starts
        run_search(0, 0, 0, 0, 40);
        run_search(20, 0, 0, 1, -1);

        // randomized searches
        for (int i = 0; i < 6; i++) begin
            fill_base(3);
            run_search(int'($urandom_range(60)), 1'($urandom_range(1)),
                       int'($urandom_range(130, 60)), 1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/me_search_engine.md
Name: me_search_engine

Overview:
Parametrised full-search block-matching motion-estimation engine for the 4K60 ME datapath. It accumulates the SAD of one BLK x BLK current block against LANES vertical candidates in parallel, stepping through COLS horizontal candidates. It reports the minimum SAD and its motion vector. Compared with the fixed 16-lane core, it adds: generic sizes, a valid/ready input handshake, start/done control, deterministic tie-breaking, and optional early termination on a SAD threshold.

Parameters:
PIX_W, 8, pixel bit width
BLK, 8, block edge in pixels (rows per candidate, pixels per row)
LANES, 16, parallel vertical candidates (mv_y range 0..LANES-1)
COLS, 16, horizontal candidates (mv_x range 0..COLS-1)
SAD_W, $clog2(BLK*BLK*(2**PIX_W-1)+1), SAD width (14 at defaults), derived, do not override

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins a search when IDLE
early_en  in  1  enable early termination; sampled at start
thresh  in  SAD_W  early-termination threshold; sampled at start
in_valid  in  1  beat valid
in_ready  out  1  engine accepts a beat (high only in RUN)
crt_row  in  BLK*PIX_W  current-block row, pixel 0 in LSBs
pre_rows  in  LANES*BLK*PIX_W  reference row per lane, lane 0 in LSBs
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse when results are final
early_term  out  1  search ended by threshold; held with results
sad_min  out  SAD_W  minimum SAD
mv_x  out  $clog2(COLS)  column index of minimum
mv_y  out  $clog2(LANES)  lane index of minimum

Behaviour:
- Beat = in_valid & in_ready. Beat order: row r=0..BLK-1 within column c, columns c=0..COLS-1. Total COLS*BLK beats.
- FSM: IDLE -> RUN on start; RUN -> DRAIN after last beat or on early hit; DRAIN -> DONE after pipeline empties (2 cycles); DONE -> IDLE next cycle (done=1 in DONE only). start outside IDLE is ignored.
- On start: sad_min <= all-ones, mv_x/mv_y <= 0, early_term <= 0, row/col counters <= 0; latch early_en/thresh.
- Stage 1 (per lane, registered): sum of |crt-pre| over BLK pixels, zero-extended to SAD_W; accumulated into the lane accumulator, which clears on row 0.
- After row BLK-1, lane SADs are valid (registered flag with column tag). Next cycle: combinational compare tree, then running-min update.
- Tie rule: tree picks the lowest lane; running min updates only on strictly smaller SAD, so the earlier column is kept. Same for all lanes.
- Latency: last beat to done = 3 cycles (accum register, compare/update register, DONE).
- Early termination: if early_en and an updated sad_min <= thresh, in_ready drops the next cycle, early_term=1, FSM goes to DRAIN. Beats already accepted within a partial column are discarded.
- Stalls: in_valid low holds all counters; there is no timeout.
- Outputs hold from DONE until the next start.
- Reset, including mid-search: IDLE, in_ready=0, busy=0, done=0, early_term=0, sad_min=all-ones, mv_x=0, mv_y=0, counters and accumulators 0.
- No overflow: SAD_W is sized for the worst case (all diffs 2**PIX_W-1 gives 16320 at defaults).

Decomposition:
- Package me_pkg: state enum (IDLE, RUN, DRAIN, DONE), SAD_W computation function, lane/column index width helpers.
- Sub-module me_sad_lane: per-lane row abs-diff sum plus accumulator, instantiated LANES times.
- Compare tree: generate-loop inside the top.

Test Plan:
1. Defaults; pre equals crt only at lane 5, column 9; other diffs 1 -> done 3 cycles after beat 128; sad_min=0, mv_x=9, mv_y=5.
2. All pixels crt=255, pre=0 -> sad_min=16320, mv_x=0, mv_y=0 (ties keep first), early_term=0.
3. Lanes 3 and 7 both SAD=10 in column 4, column 12 lane 1 SAD=10, others larger -> mv_x=4, mv_y=3.
4. early_en=1, thresh=20; column 2 lane 0 SAD=15 -> in_ready low after column 2 result, early_term=1, done pulses, sad_min=15, mv=(2,0), no further beats accepted.
5. Random in_valid gaps (~50%) on scenario 1 -> identical results; in_ready stays high through gaps in RUN.
6. rst asserted mid-RUN at beat 40, then a new start -> outputs at reset values; second search result matches a clean run; start pulses during RUN/DRAIN are ignored.
